fetch_ctrl: RTL and testbench

- Fetch-side controller that feeds the decode stage of the 5-stage pipeline.
- Owns the fetch PC and drives the instruction bus with a single outstanding request.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Handles redirects (branch/jump) by flushing the FIFO and discarding any in-flight response.

---
 rtl/pipes.sv | 34 +++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipes.sv
// Shared types and constants for the fetch front end: FSM states, FIFO entry
// layout and the instruction-bus request/response structs.
package pipes;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DROP_REQ,
        DROP_WAIT
    } fetch_state_t;

    typedef struct packed {
        u64 pc;
        u32 instr;
    } fetch_entry_t;

    typedef struct packed {
        logic valid;
        u64   addr;
    } ibus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u32   data;
    } ibus_resp_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetched {pc, instr} entries; flush empties it and
// wins over a simultaneous push or pop.
module fetch_fifo
    import pipes::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // NOTE: the storage array has no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the fetch PC, keeps one instruction-bus request in
// flight, buffers responses for decode and squashes stale work on redirect.
module fetch_ctrl
    import pipes::*;
#(
    parameter logic [63:0] RESET_PC = pipes::RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int               CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    fetch_state_t     state_q;
    logic [63:0]      pc_q;
    logic [63:0]      tgt_pc_q;
    logic             req_valid_q;

    fetch_entry_t     head;
    logic [CNT_W-1:0] fifo_count;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] cnt_after_pop;
    logic [CNT_W-1:0] cnt_after_push;

    assign out_valid      = (fifo_count != '0);
    assign pop            = out_valid && out_ready && !redirect_valid;
    assign push           = (state_q == WAIT) && iresp.data_ok && !redirect_valid;
    assign cnt_after_pop  = fifo_count - CNT_W'(pop);
    assign cnt_after_push = cnt_after_pop + CNT_W'(1);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .push_data_i ('{pc: pc_q, instr: iresp.data}),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    // Requests are only launched with room to spare, so a push can never overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            tgt_pc_q    <= '0;
            req_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_valid) begin
                        pc_q        <= redirect_pc;
                        state_q     <= REQ;
                        req_valid_q <= 1'b1;
                    end else if (cnt_after_pop < FULL) begin
                        state_q     <= REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        tgt_pc_q <= redirect_pc;
                        if (iresp.addr_ok) begin
                            state_q     <= DROP_WAIT;
                            req_valid_q <= 1'b0;
                        end else begin
                            state_q <= DROP_REQ;
                        end
                    end else if (iresp.addr_ok) begin
                        state_q     <= WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        if (iresp.data_ok) begin
                            pc_q        <= redirect_pc;
                            state_q     <= REQ;
                            req_valid_q <= 1'b1;
                        end else begin
                            tgt_pc_q <= redirect_pc;
                            state_q  <= DROP_WAIT;
                        end
                    end else if (iresp.data_ok) begin
                        pc_q <= pc_q + 64'd4;
                        if (cnt_after_push < FULL) begin
                            state_q     <= REQ;
                            req_valid_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DROP_REQ: begin
                    if (redirect_valid) tgt_pc_q <= redirect_pc;
                    if (iresp.addr_ok) begin
                        state_q     <= DROP_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                DROP_WAIT: begin
                    // The newest redirect target wins if one lands with the stale response.
                    if (iresp.data_ok) begin
                        pc_q        <= redirect_valid ? redirect_pc : tgt_pc_q;
                        state_q     <= REQ;
                        req_valid_q <= 1'b1;
                    end else if (redirect_valid) begin
                        tgt_pc_q <= redirect_pc;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ireq      = '{valid: req_valid_q, addr: pc_q};
    assign out_pc    = out_valid ? head.pc : '0;
    assign out_instr = out_valid ? head.instr : '0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a configurable instruction-bus responder
// (addr_ok stall count, data_ok latency, returned data word).
module tb_fetch_ctrl;
    import pipes::*;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] STALE = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;

    int          tests_run    = 0;
    int          tests_failed = 0;

    int          stall_cnt = 0;
    int          data_lat  = 1;
    logic [31:0] data_val  = NOP;

    fetch_ctrl #(.RESET_PC(BASE), .DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    // Bus responder: drives iresp on the falling edge from what the DUT showed at the last rising edge.
    initial begin
        int wait_cnt;
        wait_cnt = -1;
        iresp    = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                wait_cnt = -1;
            end else begin
                if (iresp.data_ok) wait_cnt = -1;
                else if (wait_cnt > 0) wait_cnt--;
                if (iresp.addr_ok) wait_cnt = data_lat - 1;
            end
            iresp.data_ok = (wait_cnt == 0);
            iresp.data    = data_val;
            iresp.addr_ok = 1'b0;
            if (reset && ireq.valid) begin
                if (stall_cnt > 0) stall_cnt--;
                else iresp.addr_ok = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic ready);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = ready;
        stall_cnt      = 0;
        data_lat       = 1;
        data_val       = NOP;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        tick();
        tick();
        tests_run++; if (ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b want 0", ireq.valid); end
        tests_run++; if (ireq.addr !== BASE) begin tests_failed++; $display("FAIL reset_req_addr: got %h want %h", ireq.addr, BASE); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests_run++; if (out_pc !== 64'd0) begin tests_failed++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
        tests_run++; if (out_instr !== 32'd0) begin tests_failed++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
    endtask

    task automatic test_basic();
        logic [63:0] exp_pc;
        apply_reset(1'b1);
        tick();
        tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== BASE) begin tests_failed++; $display("FAIL basic_first_req: got v=%b a=%h want v=1 a=%h", ireq.valid, ireq.addr, BASE); end
        for (int k = 0; k < 3; k++) begin
            exp_pc = BASE + 64'(4 * k);
            tick();
            tests_run++; if (ireq.valid !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_wait k=%0d: got req_v=%b out_v=%b want 0 0", k, ireq.valid, out_valid); end
            tick();
            tests_run++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== NOP) begin tests_failed++; $display("FAIL basic_out k=%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, out_valid, out_pc, out_instr, exp_pc, NOP); end
            tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== exp_pc + 64'd4) begin tests_failed++; $display("FAIL basic_next_req k=%0d: got v=%b a=%h want v=1 a=%h", k, ireq.valid, ireq.addr, exp_pc + 64'd4); end
        end
    endtask

    task automatic test_backpressure();
        apply_reset(1'b0);
        repeat (5) tick();
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (out_valid !== 1'b1 || out_pc !== BASE || ireq.valid !== 1'b0 || dut.fifo_count !== 2'd2) begin tests_failed++; $display("FAIL bp_full i=%0d: got v=%b pc=%h req_v=%b cnt=%0d want v=1 pc=%h req_v=0 cnt=2", i, out_valid, out_pc, ireq.valid, dut.fifo_count, BASE); end
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++; if (out_pc !== BASE + 64'd4 || dut.fifo_count !== 2'd1) begin tests_failed++; $display("FAIL bp_pop: got pc=%h cnt=%0d want pc=%h cnt=1", out_pc, dut.fifo_count, BASE + 64'd4); end
        tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== BASE + 64'd8) begin tests_failed++; $display("FAIL bp_new_req: got v=%b a=%h want v=1 a=%h", ireq.valid, ireq.addr, BASE + 64'd8); end
        tick();
        tick();
        tests_run++; if (dut.fifo_count !== 2'd2 || ireq.valid !== 1'b0 || out_pc !== BASE + 64'd4) begin tests_failed++; $display("FAIL bp_refill: got cnt=%0d req_v=%b pc=%h want cnt=2 req_v=0 pc=%h", dut.fifo_count, ireq.valid, out_pc, BASE + 64'd4); end
    endtask

    task automatic test_addr_stall();
        apply_reset(1'b1);
        stall_cnt = 3;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== BASE) begin tests_failed++; $display("FAIL stall_hold i=%0d: got v=%b a=%h want v=1 a=%h", i, ireq.valid, ireq.addr, BASE); end
        end
        tick();
        tests_run++; if (ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL stall_accept: got v=%b want 0", ireq.valid); end
        tick();
        tests_run++; if (out_valid !== 1'b1 || out_pc !== BASE || out_instr !== NOP) begin tests_failed++; $display("FAIL stall_out: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", out_valid, out_pc, out_instr, BASE, NOP); end
    endtask

    task automatic test_redirect_wait();
        apply_reset(1'b0);
        repeat (3) tick();
        tests_run++; if (out_valid !== 1'b1 || out_pc !== BASE) begin tests_failed++; $display("FAIL rw_pre: got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, BASE); end
        data_lat = 3;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        data_val       = STALE;
        tick();
        redirect_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b0 || dut.fifo_count !== 2'd0 || ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL rw_flush: got v=%b cnt=%0d req_v=%b want 0 0 0", out_valid, dut.fifo_count, ireq.valid); end
        tick();
        tests_run++; if (out_valid !== 1'b0 || ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL rw_drop_wait: got v=%b req_v=%b want 0 0", out_valid, ireq.valid); end
        tick();
        tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0100 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_target_req: got v=%b a=%h out_v=%b want v=1 a=8000000000000100 out_v=0", ireq.valid, ireq.addr, out_valid); end
        data_lat = 1;
        data_val = NOP;
        tick();
        tick();
        tests_run++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0100 || out_instr !== NOP) begin tests_failed++; $display("FAIL rw_target_out: got v=%b pc=%h i=%h want v=1 pc=8000000000000100 i=%h", out_valid, out_pc, out_instr, NOP); end
    endtask

    task automatic test_redirect_req();
        apply_reset(1'b1);
        stall_cnt = 2;
        tick();
        tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== BASE) begin tests_failed++; $display("FAIL rq_first: got v=%b a=%h want v=1 a=%h", ireq.valid, ireq.addr, BASE); end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        data_val       = STALE;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== BASE || out_valid !== 1'b0) begin tests_failed++; $display("FAIL rq_hold i=%0d: got v=%b a=%h out_v=%b want v=1 a=%h out_v=0", i, ireq.valid, ireq.addr, out_valid, BASE); end
            tick();
        end
        tests_run++; if (ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL rq_drop_wait: got v=%b want 0", ireq.valid); end
        tick();
        data_val = NOP;
        tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0200 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL rq_target_req: got v=%b a=%h out_v=%b want v=1 a=8000000000000200 out_v=0", ireq.valid, ireq.addr, out_valid); end
        tick();
        tick();
        tests_run++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0200 || out_instr !== NOP) begin tests_failed++; $display("FAIL rq_target_out: got v=%b pc=%h i=%h want v=1 pc=8000000000000200 i=%h", out_valid, out_pc, out_instr, NOP); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset(1'b0);
        repeat (4) tick();
        tests_run++; if (out_valid !== 1'b1 || ireq.valid !== 1'b0) begin tests_failed++; $display("FAIL mid_pre: got v=%b req_v=%b want v=1 req_v=0", out_valid, ireq.valid); end
        reset = 1'b0;
        #1;
        tests_run++; if (ireq.valid !== 1'b0 || ireq.addr !== BASE) begin tests_failed++; $display("FAIL mid_req: got v=%b a=%h want v=0 a=%h", ireq.valid, ireq.addr, BASE); end
        tests_run++; if (out_valid !== 1'b0 || out_pc !== 64'd0 || out_instr !== 32'd0) begin tests_failed++; $display("FAIL mid_out: got v=%b pc=%h i=%h want 0 0 0", out_valid, out_pc, out_instr); end
        tests_run++; if (dut.fifo_count !== 2'd0) begin tests_failed++; $display("FAIL mid_count: got %0d want 0", dut.fifo_count); end
        tick();
        reset = 1'b1;
        tick();
        tests_run++; if (ireq.valid !== 1'b1 || ireq.addr !== BASE) begin tests_failed++; $display("FAIL mid_restart: got v=%b a=%h want v=1 a=%h", ireq.valid, ireq.addr, BASE); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_addr_stall();
        test_redirect_wait();
        test_redirect_req();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
